// File: rtl/snes_ctrl_pkg.sv
// Shared definitions for the SNES controller-port transmitter: FSM encoding,
// button bit positions in the serial frame, and wire-level constants.
package snes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  localparam int NBITS_DEF = 16;

  // Bit position in the frame; bit 0 is the first bit the console reads.
  localparam int BTN_B   = 0;
  localparam int BTN_Y   = 1;
  localparam int BTN_SEL = 2;
  localparam int BTN_STA = 3;
  localparam int BTN_UP  = 4;
  localparam int BTN_DN  = 5;
  localparam int BTN_LF  = 6;
  localparam int BTN_RT  = 7;
  localparam int BTN_A   = 8;
  localparam int BTN_X   = 9;
  localparam int BTN_L   = 10;
  localparam int BTN_R   = 11;

  // Wire is active low: 1 means no button pressed, 0 reads as logical 1.
  localparam logic WIRE_IDLE = 1'b1;
  localparam logic WIRE_DONE = 1'b0;

endpackage

// File: rtl/snes_ctrl_sync.sv
// Synchronizer and registered rise/fall pulse generator for one console line.
// With CTRL_FILTER_EN defined, a FILT_LEN-sample stability filter sits before edge detect.
module snes_ctrl_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
`ifdef CTRL_FILTER_EN
  ,
  parameter int   FILT_LEN    = 3
`endif
) (
  input  logic CLK_i,
  input  logic RST_i,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   lvl_q;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef CTRL_FILTER_EN
  logic [FILT_LEN-2:0] hist_q;
  logic                filt_q;

  // The current sample plus FILT_LEN-1 older ones must agree before the level moves.
  always_comb begin
    if (&{hist_q, sync_q[SYNC_STAGES-1]})       lvl = 1'b1;
    else if (~|{hist_q, sync_q[SYNC_STAGES-1]}) lvl = 1'b0;
    else                                        lvl = filt_q;
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      hist_q <= {(FILT_LEN-1){RST_VAL}};
      filt_q <= RST_VAL;
    end else begin
      hist_q[0] <= sync_q[SYNC_STAGES-1];
      for (int i = 1; i < FILT_LEN-1; i++) hist_q[i] <= hist_q[i-1];
      filt_q <= lvl;
    end
  end
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      lvl_q <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      rise  <= lvl & ~lvl_q;
      fall  <= ~lvl & lvl_q;
    end
  end

endmodule

// File: rtl/snes_ctrl_tx.sv
// SNES joypad emulator: answers console LATCH/CLK with a serial button frame.
// Define CTRL_FILTER_EN to add a glitch filter on both console inputs.
//
// state | meaning
// IDLE  | no frame; wire shows pending bit 0
// LATCH | latch high; shift register follows pending every cycle
// SHIFT | each console clock rise advances one bit
// DONE  | all bits sent; wire held low until next latch or timeout
module snes_ctrl_tx
  import snes_ctrl_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
`ifdef CTRL_FILTER_EN
  ,
  parameter int FILT_LEN    = 3
`endif
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             CTRL_LATCH_i,
  input  logic             CTRL_CLK_i,
  output logic             CTRL_SDATA_o,
  input  logic [NBITS-1:0] pdata_i,
  input  logic             pdata_valid_i,
  output logic             pdata_ack_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic [4:0]       bit_cnt_o
);

  localparam logic [4:0]  LAST_BIT = 5'(NBITS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  ctrl_state_t      state_q, state_d;
  logic [NBITS-1:0] pending_q;
  logic [NBITS-1:0] shreg_q;
  logic [4:0]       bit_cnt_q;
  logic [15:0]      tmo_q;
  logic             ack_q, done_q;
  logic             latch_rise, latch_fall, clk_rise, clk_fall;
  logic             tmo_hit;

  snes_ctrl_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
`ifdef CTRL_FILTER_EN
    ,
    .FILT_LEN   (FILT_LEN)
`endif
  ) u_sync_latch (
    .CLK_i(CLK_i), .RST_i(RST_i), .din(CTRL_LATCH_i),
    .rise (latch_rise), .fall(latch_fall)
  );

  // Console clock idles high, so its synchronizer resets high to avoid a false fall.
  snes_ctrl_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
`ifdef CTRL_FILTER_EN
    ,
    .FILT_LEN   (FILT_LEN)
`endif
  ) u_sync_clk (
    .CLK_i(CLK_i), .RST_i(RST_i), .din(CTRL_CLK_i),
    .rise (clk_rise), .fall(clk_fall)
  );

  assign tmo_hit = (tmo_q >= TMO_LAST);

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A latch rise always wins over a simultaneous clock rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (latch_rise) state_d = ST_LATCH;
      ST_LATCH: if (latch_fall) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (latch_rise)                          state_d = ST_LATCH;
        else if (clk_rise && bit_cnt_q == LAST_BIT) state_d = ST_DONE;
        else if (!clk_rise && !clk_fall && tmo_hit) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (latch_rise)                          state_d = ST_LATCH;
        else if (!clk_rise && !clk_fall && tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CTRL_SDATA_o = WIRE_IDLE;
    busy_o       = 1'b0;
    case (state_q)
      ST_IDLE:  CTRL_SDATA_o = ~pending_q[0];
      ST_LATCH, ST_SHIFT: begin
        CTRL_SDATA_o = ~shreg_q[0];
        busy_o       = 1'b1;
      end
      ST_DONE:  CTRL_SDATA_o = WIRE_DONE;
      default:  CTRL_SDATA_o = WIRE_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      pending_q <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (pdata_valid_i) pending_q <= pdata_i;
      ack_q  <= pdata_valid_i;
      done_q <= (state_q == ST_SHIFT) && (state_d == ST_DONE);

      if (state_d == ST_LATCH) begin
        shreg_q   <= pending_q;
        bit_cnt_q <= '0;
      end else if (state_q == ST_SHIFT && clk_rise) begin
        shreg_q   <= shreg_q >> 1;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end

      if (state_d != state_q || clk_rise || clk_fall) tmo_q <= '0;
      else if (tmo_q != '1)                           tmo_q <= tmo_q + 16'd1;
    end
  end

  assign pdata_ack_o  = ack_q;
  assign frame_done_o = done_q;
  assign bit_cnt_o    = bit_cnt_q;

endmodule

// File: tb/tb_snes_ctrl_tx.sv
// Scoreboard bench for snes_ctrl_tx: expected wire bits are queued by the stimulus and
// checked by a monitor at each console clock fall. Honors CTRL_FILTER_EN.
module tb_snes_ctrl_tx;

  localparam int NB  = 16;
  localparam int SS  = 2;
  localparam int TMO = 4096;
`ifdef CTRL_FILTER_EN
  localparam int FL  = 3;
  localparam int LAT = SS + 2 + FL - 1;
`else
  localparam int LAT = SS + 2;
`endif

  logic          CLK_i = 1'b0;
  logic          RST_i = 1'b1;
  logic          CTRL_LATCH_i = 1'b0;
  logic          CTRL_CLK_i = 1'b1;
  logic [NB-1:0] pdata_i = '0;
  logic          pdata_valid_i = 1'b0;
  logic          CTRL_SDATA_o, pdata_ack_o, frame_done_o, busy_o;
  logic [4:0]    bit_cnt_o;

  int cmp_cnt  = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b1;
  logic exp_q[$];

  snes_ctrl_tx #(
    .NBITS(NB), .SYNC_STAGES(SS), .TIMEOUT_CYC(TMO)
`ifdef CTRL_FILTER_EN
    , .FILT_LEN(FL)
`endif
  ) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .CTRL_LATCH_i(CTRL_LATCH_i), .CTRL_CLK_i(CTRL_CLK_i),
    .CTRL_SDATA_o(CTRL_SDATA_o), .pdata_i(pdata_i), .pdata_valid_i(pdata_valid_i),
    .pdata_ack_o(pdata_ack_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
    .bit_cnt_o(bit_cnt_o)
  );

  always #20 CLK_i = ~CLK_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Console samples the wire on each clock fall.
  always @(negedge CTRL_CLK_i) begin : wire_mon
    logic e;
    if (mon_en && !RST_i) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL wire_sample: got %b, no bit expected", CTRL_SDATA_o);
      end else begin
        e = exp_q.pop_front();
        check("wire_sample", {31'd0, CTRL_SDATA_o}, {31'd0, e});
      end
    end
  end

  always @(negedge CLK_i) if (frame_done_o) done_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_i);
  endtask

  task automatic load(input logic [NB-1:0] w);
    @(negedge CLK_i);
    pdata_i = w;
    pdata_valid_i = 1'b1;
    @(negedge CLK_i);
    pdata_valid_i = 1'b0;
    check("pdata_ack", {31'd0, pdata_ack_o}, 32'd1);
    @(negedge CLK_i);
    check("pdata_ack_pulse", {31'd0, pdata_ack_o}, 32'd0);
  endtask

  task automatic latch_pulse();
    CTRL_LATCH_i = 1'b1;
    cyc(300);
    CTRL_LATCH_i = 1'b0;
    cyc(75);
  endtask

  task automatic clk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      CTRL_CLK_i = 1'b0;
      cyc(75);
      CTRL_CLK_i = 1'b1;
      cyc(75);
    end
  endtask

  // Wire level for bit i is the inverted button bit; past the frame it reads 0.
  task automatic push_frame(input logic [NB-1:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i < NB ? ~w[i] : 1'b0);
  endtask

  initial begin : stim
    int n;
    cyc(5);
    check("rst_sdata",   {31'd0, CTRL_SDATA_o}, 32'd1);
    check("rst_ack",     {31'd0, pdata_ack_o},  32'd0);
    check("rst_done",    {31'd0, frame_done_o}, 32'd0);
    check("rst_busy",    {31'd0, busy_o},       32'd0);
    check("rst_bit_cnt", {27'd0, bit_cnt_o},    32'd0);
    RST_i = 1'b0;
    cyc(5);

    // Full frame: bit0 and bit7 pressed.
    load(16'h0081);
    check("idle_sdata", {31'd0, CTRL_SDATA_o}, 32'd0);
    push_frame(16'h0081, NB);
    latch_pulse();
    check("shift_busy",    {31'd0, busy_o},    32'd1);
    check("shift_bit_cnt", {27'd0, bit_cnt_o}, 32'd0);
    clk_pulses(NB);
    check("frame_bit_cnt", {27'd0, bit_cnt_o}, 32'd16);
    check("frame_busy",    {31'd0, busy_o},    32'd0);
    check("frame_sdata",   {31'd0, CTRL_SDATA_o}, 32'd0);
    check("frame_done_1",  done_cnt, 32'd1);

    // Extra clocks after the frame.
    push_frame(16'h0000, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    clk_pulses(4);
    check("extra_bit_cnt", {27'd0, bit_cnt_o},    32'd16);
    check("extra_sdata",   {31'd0, CTRL_SDATA_o}, 32'd0);
    check("extra_done",    done_cnt, 32'd1);

    // Mid-frame abort; pending changes during SHIFT must not disturb the frame.
    load(16'hF00F);
    push_frame(16'hF00F, 5);
    latch_pulse();
    clk_pulses(3);
    load(16'h00A5);
    clk_pulses(2);
    check("abort_pre_cnt", {27'd0, bit_cnt_o}, 32'd5);
    CTRL_LATCH_i = 1'b1;
    cyc(LAT + 2);
    check("abort_bit_cnt", {27'd0, bit_cnt_o},    32'd0);
    check("abort_busy",    {31'd0, busy_o},       32'd1);
    check("abort_sdata",   {31'd0, CTRL_SDATA_o}, 32'd0);
    check("abort_no_done", done_cnt, 32'd1);
    cyc(298);
    CTRL_LATCH_i = 1'b0;
    cyc(75);
    push_frame(16'h00A5, NB);
    clk_pulses(NB);
    check("reload_done",    done_cnt, 32'd2);
    check("reload_bit_cnt", {27'd0, bit_cnt_o}, 32'd16);

    // Reset while shifting bit 7.
    load(16'h0F0F);
    push_frame(16'h0F0F, 7);
    latch_pulse();
    clk_pulses(7);
    check("pre_rst_bit_cnt", {27'd0, bit_cnt_o}, 32'd7);
    RST_i = 1'b1;
    cyc(1);
    check("midrst_sdata",   {31'd0, CTRL_SDATA_o}, 32'd1);
    check("midrst_busy",    {31'd0, busy_o},       32'd0);
    check("midrst_bit_cnt", {27'd0, bit_cnt_o},    32'd0);
    check("midrst_done",    done_cnt, 32'd2);
    RST_i = 1'b0;
    cyc(5);

    // Clocks stop after bit 9: timeout back to IDLE.
    load(16'hFFFF);
    push_frame(16'hFFFF, 9);
    latch_pulse();
    clk_pulses(8);
    CTRL_CLK_i = 1'b0;
    cyc(75);
    CTRL_CLK_i = 1'b1;
    cyc(10);
    n = 10;
    check("tmo_bit_cnt", {27'd0, bit_cnt_o}, 32'd9);
    check("tmo_busy_pre", {31'd0, busy_o}, 32'd1);
    while (n < LAT + TMO + 50) begin
      @(posedge CLK_i);
      n++;
      #1;
      if (!busy_o) break;
    end
    check("tmo_cycles",   n, LAT + TMO);
    check("tmo_busy",     {31'd0, busy_o},       32'd0);
    check("tmo_sdata",    {31'd0, CTRL_SDATA_o}, 32'd0);
    check("tmo_no_done",  done_cnt, 32'd2);
    cyc(2);

`ifdef CTRL_FILTER_EN
    load(16'h0003);
    latch_pulse();
    mon_en = 1'b0;
    CTRL_CLK_i = 1'b0;
    cyc(2);
    CTRL_CLK_i = 1'b1;
    cyc(20);
    check("filt_glitch", {27'd0, bit_cnt_o}, 32'd0);
    CTRL_CLK_i = 1'b0;
    cyc(3);
    CTRL_CLK_i = 1'b1;
    cyc(20);
    check("filt_pulse", {27'd0, bit_cnt_o}, 32'd1);
    mon_en = 1'b1;
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
